mips_mc_ctrl: RTL and testbench

Multicycle main control FSM for the MIPS datapath. It sits directly upstream of the ALU and drives its 4-bit operation select plus every datapath enable. It consumes the latched instruction fields and the ALU Zero flag, and sequences each instruction through the fetch, decode, execute, memory and write-back states. Memory accesses are stretched to a parameterised latency.

---
 rtl/mips_mc_ctrl_if.sv | 31 +++
 rtl/mips_mc_ctrl.sv | 142 ++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: instruction fields in, datapath enables and ALU op out
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] pc_source;
  logic [3:0] alu_ctr;
  logic [3:0] state;
  logic       illegal;
  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, imm_zext, pc_source, alu_ctr, state, illegal
  );
  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, imm_zext, pc_source, alu_ctr, state, illegal
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS main control FSM with stretched memory states
module mips_mc_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input logic           clk,
  input logic           rst_n,
  mips_mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_IMM_EXEC = 4'd10, S_IMM_WB = 4'd11,
    S_RST = 4'd14, S_TRAP = 4'd15
  } state_t;
  state_t           state_q, state_d, dec_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [3:0]       f_ctr, imm_ctr;
  logic             f_ok, last, imm_zx;
  always_comb begin
    f_ctr = bus.funct == 6'b100100 ? 4'd0 :
            bus.funct == 6'b100101 ? 4'd1 :
            bus.funct == 6'b100000 ? 4'd2 :
            bus.funct == 6'b100010 ? 4'd6 :
            bus.funct == 6'b101010 ? 4'd7 :
            bus.funct == 6'b100111 ? 4'd12 : 4'd15;
    f_ok = f_ctr != 4'd15;
    imm_ctr = bus.opcode == 6'b001100 ? 4'd0 :
              bus.opcode == 6'b001101 ? 4'd1 :
              bus.opcode == 6'b001010 ? 4'd7 : 4'd2;
    imm_zx = bus.opcode == 6'b001100 || bus.opcode == 6'b001101;
    last = cnt_q == CNT_W'(MEM_LAT - 1);
    dec_next = bus.opcode == 6'b000000 ? (f_ok ? S_EXEC : S_TRAP) :
               (bus.opcode == 6'b100011 || bus.opcode == 6'b101011) ? S_MEM_ADDR :
               (bus.opcode == 6'b000100 || bus.opcode == 6'b000101) ? S_BRANCH :
               bus.opcode == 6'b000010 ? S_JUMP :
               (bus.opcode == 6'b001000 || bus.opcode == 6'b001100 ||
                bus.opcode == 6'b001101 || bus.opcode == 6'b001010) ? S_IMM_EXEC : S_TRAP;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = state_q == S_FETCH ? S_DECODE : state_q == S_MEM_READ ? S_MEM_WB : S_FETCH;
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = dec_next;
      end
      S_MEM_ADDR: state_d = op_q == 6'b101011 ? S_MEM_WRITE : S_MEM_READ;
      S_EXEC:     state_d = S_R_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  assign bus.state = state_q;
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.imm_zext   = 1'b0;
    bus.pc_source  = 2'b00;
    bus.alu_ctr    = 4'd2;
    bus.illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = last;
        bus.pc_en     = last;
      end
      S_DECODE:   bus.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_MEM_WB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctr   = f_ok ? f_ctr : 4'd2;
      end
      S_R_WB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      S_IMM_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_ctr   = imm_ctr;
        bus.imm_zext  = imm_zx;
      end
      S_IMM_WB:   bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctr   = 4'd6;
        bus.pc_source = 2'b01;
        bus.pc_en     = op_q == 6'b000101 ? ~bus.zero : bus.zero;
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_en     = 1'b1;
      end
      S_TRAP:     bus.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: randomized and directed instruction sequences checked against a per-instruction trace model
module tb_mips_mc_ctrl;
  logic        clk = 1'b0;
  logic        r1_n, r3_n;
  logic [5:0]  op, fn;
  logic        z;
  int          tests = 0, fails = 0, sel = 0;
  logic [22:0] q[$];
  logic [22:0] v1, v3;
  logic [5:0]  ops[12] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};
  logic [5:0]  fns[6]  = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111};
  always #5 clk = ~clk;
  mips_mc_ctrl_if b1();
  mips_mc_ctrl_if b3();
  assign b1.opcode = op;
  assign b1.funct  = fn;
  assign b1.zero   = z;
  assign b3.opcode = op;
  assign b3.funct  = fn;
  assign b3.zero   = z;
  mips_mc_ctrl #(.MEM_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .rst_n(r1_n), .bus(b1));
  mips_mc_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut3 (.clk(clk), .rst_n(r3_n), .bus(b3));
  always_comb v1 = {b1.pc_en, b1.iord, b1.mem_read, b1.mem_write, b1.ir_write, b1.reg_dst, b1.mem_to_reg,
                    b1.reg_write, b1.alu_src_a, b1.alu_src_b, b1.imm_zext, b1.pc_source, b1.alu_ctr, b1.state, b1.illegal};
  always_comb v3 = {b3.pc_en, b3.iord, b3.mem_read, b3.mem_write, b3.ir_write, b3.reg_dst, b3.mem_to_reg,
                    b3.reg_write, b3.alu_src_a, b3.alu_src_b, b3.imm_zext, b3.pc_source, b3.alu_ctr, b3.state, b3.illegal};
  function automatic logic [22:0] mk(input logic [3:0] st, input logic pe, io, mr, mw, iw, rd, mtr, rw, asa,
                                     input logic [1:0] asb, input logic zx, input logic [1:0] ps, input logic [3:0] ac);
    return {pe, io, mr, mw, iw, rd, mtr, rw, asa, asb, zx, ps, ac, st, st == 4'd15};
  endfunction
  function automatic logic [22:0] rstv();
    return mk(4'd14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'd2);
  endfunction
  // ALU op for each legal R-type funct; bit 4 flags legality
  function automatic logic [4:0] rfn(input logic [5:0] f);
    case (f)
      6'b100100: return 5'h10;
      6'b100101: return 5'h11;
      6'b100000: return 5'h12;
      6'b100010: return 5'h16;
      6'b101010: return 5'h17;
      6'b100111: return 5'h1c;
      default:   return 5'h00;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [22:0] e);
    logic [22:0] a;
    int n;
    a = sel != 0 ? v3 : v1;
    tests++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, a, e);
    end
    n = int'(a[22]) + int'(a[19]) + int'(a[18]) + int'(a[15]);
    tests++;
    assert (n <= 1 || (n == 2 && a[22] && a[18])) else begin
      fails++;
      $error("FAIL %s_excl: got strobes %b expected mutually exclusive", tag, {a[22], a[19], a[18], a[15]});
    end
  endtask
  task automatic model(input int L, input logic [5:0] o, f, input logic zz, output bit trap);
    logic [4:0] r;
    logic [3:0] ac;
    r = rfn(f);
    trap = 0;
    for (int k = 0; k < L; k++) q.push_back(mk(4'd0, k == L-1, 0, 1, 0, k == L-1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 4'd2));
    q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 4'd2));
    if (o == 6'h00 && r[4]) begin
      q.push_back(mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, r[3:0]));
      q.push_back(mk(4'd7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 4'd2));
    end else if (o == 6'h23 || o == 6'h2b) begin
      q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 4'd2));
      for (int k = 0; k < L; k++)
        q.push_back(mk(o == 6'h23 ? 4'd3 : 4'd5, 0, 1, o == 6'h23, o == 6'h2b, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'd2));
      if (o == 6'h23) q.push_back(mk(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 4'd2));
    end else if (o == 6'h04 || o == 6'h05) begin
      q.push_back(mk(4'd8, o == 6'h04 ? zz : !zz, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 4'd6));
    end else if (o == 6'h02) begin
      q.push_back(mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 4'd2));
    end else if (o == 6'h08 || o == 6'h0c || o == 6'h0d || o == 6'h0a) begin
      ac = o == 6'h0c ? 4'd0 : o == 6'h0d ? 4'd1 : o == 6'h0a ? 4'd7 : 4'd2;
      q.push_back(mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, o == 6'h0c || o == 6'h0d, 2'b00, ac));
      q.push_back(mk(4'd11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 4'd2));
    end else begin
      trap = 1;
      for (int k = 0; k < 20; k++) q.push_back(mk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4'd2));
    end
  endtask
  task automatic do_reset(input string tag);
    if (sel != 0) r3_n = 1'b0; else r1_n = 1'b0;
    #1 chk({tag, "_rst_now"}, rstv());
    @(negedge clk);
    chk({tag, "_rst_held"}, rstv());
    if (sel != 0) r3_n = 1'b1; else r1_n = 1'b1;
  endtask
  task automatic run(input logic [5:0] o, f, input logic zz, input string tag);
    bit trap;
    op = o;
    fn = f;
    z  = zz;
    q.delete();
    model(sel != 0 ? 3 : 1, o, f, zz, trap);
    foreach (q[i]) begin
      @(negedge clk);
      chk(tag, q[i]);
    end
    if (trap) do_reset(tag);
  endtask
  task automatic run_random(input int n);
    logic [5:0] o, f;
    for (int i = 0; i < n; i++) begin
      o = $urandom_range(0, 15) == 0 ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 11)];
      f = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
      run(o, f, 1'($urandom_range(0, 1)), "rand");
    end
  endtask
  initial begin
    r1_n = 1'b0;
    r3_n = 1'b0;
    op = '0;
    fn = '0;
    z = 1'b0;
    sel = 0;
    @(negedge clk);
    chk("rst1", rstv());
    r1_n = 1'b1;
    run(6'h00, 6'b100000, 0, "add_lat1");
    run(6'h23, 6'h00, 0, "lw_lat1");
    run(6'h2b, 6'h00, 1, "sw_lat1");
    run_random(40);
    sel = 1;
    r1_n = 1'b0;
    @(negedge clk);
    chk("rst3", rstv());
    r3_n = 1'b1;
    run(6'h23, 6'h00, 0, "lw_lat3");
    run(6'h04, 6'h00, 1, "beq_z1");
    run(6'h04, 6'h00, 0, "beq_z0");
    run(6'h05, 6'h00, 0, "bne_z0");
    run(6'h05, 6'h00, 1, "bne_z1");
    run(6'h0d, 6'h00, 0, "ori");
    run(6'h0a, 6'h00, 0, "slti");
    run(6'h0c, 6'h00, 0, "andi");
    run(6'h02, 6'h00, 0, "j");
    run(6'h00, 6'b100111, 0, "nor");
    run(6'h3f, 6'h00, 0, "trap_op");
    run(6'h00, 6'b000001, 0, "trap_funct");
    op = 6'h2b;
    fn = 6'h00;
    q.delete();
    begin
      bit t;
      model(3, 6'h2b, 6'h00, 0, t);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("sw_abort", q[i]);
    end
    do_reset("sw_abort");
    run(6'h2b, 6'h00, 0, "sw_after_abort");
    run_random(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
